// File: rtl/gcd_scheduler_if.sv
// rtl/gcd_scheduler_if.sv - requester-side bus of the shared GCD scheduler
//
// Groups the request/operand/completion signals of all N requesters.
//   req    : per-requester request level, held with operands until ack
//   a_in   : operand A, requester i at [i*W +: W]
//   b_in   : operand B, same packing
//   ack    : one-cycle completion pulse to the granted requester
//   err    : one-cycle pulse alongside ack when the job timed out
//   result : GCD result, valid in the ack cycle and held until the next ack
// The master modport is the requester side and the slave modport is the scheduler.
// W and N must match the parameters of the gcd_scheduler instance.

interface gcd_scheduler_if #(
  parameter int W = 8,
  parameter int N = 4
);
  logic [N-1:0]   req;
  logic [N*W-1:0] a_in;
  logic [N*W-1:0] b_in;
  logic [N-1:0]   ack;
  logic [N-1:0]   err;
  logic [W-1:0]   result;

  modport master (output req, a_in, b_in, input ack, err, result);
  modport slave  (input req, a_in, b_in, output ack, err, result);
endinterface

// File: rtl/gcd_scheduler.sv
// rtl/gcd_scheduler.sv - round-robin scheduler sharing one iterative GCD unit
//
// Arbitrates N requesters onto a single GCD unit. It latches the winner's
// operands, drives the unit's start/done handshake and guards each run with a
// cycle timeout. It then returns the result (or an error) to the granted
// requester.
//
// Ports:
//   clk        : rising-edge clock
//   rst        : asynchronous active-low reset
//   bus        : requester bus (gcd_scheduler_if.slave): req, a_in, b_in,
//                ack, err, result
//   busy       : high whenever the scheduler is not idle
//   core_start : start level to the GCD unit
//   core_a     : latched operand A to the unit
//   core_b     : latched operand B to the unit
//   core_done  : done level from the GCD unit
//   core_r     : result from the GCD unit
//
// Optional feature (macro GCD_SCHED_ZERO_BYPASS_EN): a job whose granted
// operands contain a zero bypasses the unit. Its result is A|B and it is
// acknowledged one edge after the grant.

module gcd_scheduler #(
  parameter int W       = 8,
  parameter int N       = 4,
  parameter int TIMEOUT = 1000
) (
  input  logic               clk,
  input  logic               rst,
  gcd_scheduler_if.slave     bus,
  output logic               busy,
  output logic               core_start,
  output logic [W-1:0]       core_a,
  output logic [W-1:0]       core_b,
  input  logic               core_done,
  input  logic [W-1:0]       core_r
);

  localparam int IW = (N > 1) ? $clog2(N) : 1;
  localparam int CW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    RUN      = 2'd1,
    WAIT_LOW = 2'd2
  } state_t;

  state_t         state_q, state_n;
  logic [IW-1:0]  idx_q, idx_n;
  logic [IW-1:0]  rr_q, rr_n;
  logic [CW-1:0]  cnt_q, cnt_n;
  logic           start_q, start_n;
  logic [W-1:0]   a_q, a_n;
  logic [W-1:0]   b_q, b_n;
  logic [W-1:0]   result_q, result_n;
  logic [N-1:0]   ack_q, ack_n;
  logic [N-1:0]   err_q, err_n;
  logic           busy_q, busy_n;
  // Set only when the zero-operand bypass is compiled in; otherwise stays 0.
  logic           byp_q, byp_n;

  logic           grant_found;
  logic [IW-1:0]  grant_idx;
  logic [W-1:0]   grant_a;
  logic [W-1:0]   grant_b;
  logic [N-1:0]   idx_oh;

  // Round-robin search: first set req bit starting at rr_ptr+1, wrapping.
  // The last winner is therefore always examined last.
  always_comb begin
    int c;
    c           = 0;
    grant_found = 1'b0;
    grant_idx   = '0;
    for (int k = 1; k <= N; k++) begin
      c = int'(rr_q) + k;
      if (c >= N) c = c - N;
      for (int i = 0; i < N; i++) begin
        if (!grant_found && bus.req[i] && (c == i)) begin
          grant_found = 1'b1;
          grant_idx   = IW'(i);
        end
      end
    end
  end

  // Operand mux for the candidate winner; only sampled in IDLE.
  always_comb begin
    grant_a = '0;
    grant_b = '0;
    for (int i = 0; i < N; i++) begin
      if (grant_idx == IW'(i)) begin
        grant_a = bus.a_in[i*W +: W];
        grant_b = bus.b_in[i*W +: W];
      end
    end
  end

  // One-hot of the job currently owned, used to steer ack/err.
  always_comb begin
    idx_oh = '0;
    for (int i = 0; i < N; i++) begin
      if (idx_q == IW'(i)) idx_oh[i] = 1'b1;
    end
  end

  always_comb begin
    state_n  = state_q;
    idx_n    = idx_q;
    rr_n     = rr_q;
    cnt_n    = cnt_q;
    start_n  = start_q;
    a_n      = a_q;
    b_n      = b_q;
    result_n = result_q;
    ack_n    = '0;
    err_n    = '0;
    byp_n    = byp_q;

    case (state_q)
      IDLE: begin
        if (grant_found) begin
          idx_n   = grant_idx;
          rr_n    = grant_idx;
          a_n     = grant_a;
          b_n     = grant_b;
          start_n = 1'b1;
          byp_n   = 1'b0;
          state_n = RUN;
`ifdef GCD_SCHED_ZERO_BYPASS_EN
          if ((grant_a == '0) || (grant_b == '0)) begin
            start_n = 1'b0;
            byp_n   = 1'b1;
          end
`endif
        end
      end

      RUN: begin
        // Saturating: the abort fires at TIMEOUT-1, so TIMEOUT is never passed.
        if (cnt_q < CW'(TIMEOUT)) cnt_n = cnt_q + CW'(1);
        if (byp_q) begin
          result_n = a_q | b_q;
          ack_n    = idx_oh;
          start_n  = 1'b0;
          byp_n    = 1'b0;
          state_n  = WAIT_LOW;
        end else if (core_done) begin
          // done is checked first so a coincident timeout is not reported.
          result_n = core_r;
          ack_n    = idx_oh;
          start_n  = 1'b0;
          state_n  = WAIT_LOW;
        end else if (cnt_q == CW'(TIMEOUT - 1)) begin
          result_n = '0;
          ack_n    = idx_oh;
          err_n    = idx_oh;
          start_n  = 1'b0;
          state_n  = WAIT_LOW;
        end
      end

      WAIT_LOW: begin
        // The unit must drop done before it can be started again.
        if (!core_done) begin
          cnt_n   = '0;
          state_n = IDLE;
        end
      end

      default: begin
        start_n = 1'b0;
        cnt_n   = '0;
        byp_n   = 1'b0;
        state_n = IDLE;
      end
    endcase

    busy_n = (state_n != IDLE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      idx_q    <= '0;
      rr_q     <= IW'(N - 1);
      cnt_q    <= '0;
      start_q  <= 1'b0;
      a_q      <= '0;
      b_q      <= '0;
      result_q <= '0;
      ack_q    <= '0;
      err_q    <= '0;
      busy_q   <= 1'b0;
      byp_q    <= 1'b0;
    end else begin
      state_q  <= state_n;
      idx_q    <= idx_n;
      rr_q     <= rr_n;
      cnt_q    <= cnt_n;
      start_q  <= start_n;
      a_q      <= a_n;
      b_q      <= b_n;
      result_q <= result_n;
      ack_q    <= ack_n;
      err_q    <= err_n;
      busy_q   <= busy_n;
      byp_q    <= byp_n;
    end
  end

  assign bus.ack    = ack_q;
  assign bus.err    = err_q;
  assign bus.result = result_q;
  assign busy       = busy_q;
  assign core_start = start_q;
  assign core_a     = a_q;
  assign core_b     = b_q;

endmodule
